// File: rtl/noc_axilite_req_arbiter.sv
// -----------------------------------------------------------------------------
// noc_axilite_req_arbiter
//
// Lets the AXI-lite load and store request engines share one NoC request
// output. Arbitration is packet-granular and round-robin. After a header
// handshakes, its class owns the output until the last payload flit has been
// sent. Each class has an outstanding-packet credit counter capped at
// MAX_OUTST. The counter goes up on every header handshake and comes down on
// the completion pulses from the response block.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   ld_valid_in/ld_data_in         load engine flit stream (first flit = header)
//   ld_ready_out                   load flit accepted on valid && ready
//   st_valid_in/st_data_in         store engine flit stream
//   st_ready_out                   store flit accepted on valid && ready
//   noc_valid_out/noc_data_out     muxed flit stream toward the NoC
//   noc_ready_in                   NoC back-pressure
//   ld_resp_done/st_resp_done      1-cycle pulses: one ACK delivered, credit back
//   ld_outst/st_outst              in-flight packet counts per class
//   owner                          00 idle, 01 load, 10 store
//   err_underflow                  sticky: completion seen with counter at 0
// -----------------------------------------------------------------------------
module noc_axilite_req_arbiter #(
    parameter int NOC_DW      = 64,
    parameter int MSG_LEN_LSB = 22,   // LSB of the header payload-length field
    parameter int MSG_LEN_W   = 8,    // width of the header payload-length field
    parameter int MAX_OUTST   = 4,
    parameter int CNT_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid_in,
    input  logic [NOC_DW-1:0] ld_data_in,
    output logic              ld_ready_out,
    input  logic              st_valid_in,
    input  logic [NOC_DW-1:0] st_data_in,
    output logic              st_ready_out,
    output logic              noc_valid_out,
    output logic [NOC_DW-1:0] noc_data_out,
    input  logic              noc_ready_in,
    input  logic              ld_resp_done,
    input  logic              st_resp_done,
    output logic [CNT_W-1:0]  ld_outst,
    output logic [CNT_W-1:0]  st_outst,
    output logic [1:0]        owner,
    output logic              err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_PKT  = 2'd1,
        S_STORE_PKT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 rr_st_q, rr_st_d;       // 1: store wins the next tie
    logic [MSG_LEN_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [MSG_LEN_W-1:0] len_q, len_d;
    logic                 err_q, err_d;

    // Per-class vectors, index 0 = load, index 1 = store.
    logic [1:0]           valid_c, elig_c, inc_c, dec_c, uflow_c;
    logic                 grant_ld, grant_st, sel_ld, sel_st;
    logic                 flit_hs, hdr_hs;
    logic [MSG_LEN_W-1:0] hdr_len;

    assign valid_c = {st_valid_in, ld_valid_in};
    assign dec_c   = {st_resp_done, ld_resp_done};

    // Credit counters. A simultaneous grant and completion cancel out. A
    // completion at zero leaves the counter at zero and raises the error.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cred
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign elig_c[gi]  = valid_c[gi] && (cnt_q < CNT_W'(MAX_OUTST));
            assign uflow_c[gi] = dec_c[gi] && !inc_c[gi] && (cnt_q == '0);

            always_comb begin
                cnt_d = cnt_q;
                if (inc_c[gi] && !dec_c[gi]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (dec_c[gi] && !inc_c[gi] && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign ld_outst      = g_cred[0].cnt_q;
    assign st_outst      = g_cred[1].cnt_q;
    assign err_underflow = err_q;
    assign err_d         = err_q | (|uflow_c);

    // The IDLE grant is purely combinational. It is not latched, so an offered
    // header that does not handshake is arbitrated again next cycle.
    always_comb begin
        grant_ld = 1'b0;
        grant_st = 1'b0;
        if (state_q == S_IDLE) begin
            if (elig_c[0] && elig_c[1]) begin
                grant_ld = !rr_st_q;
                grant_st = rr_st_q;
            end else begin
                grant_ld = elig_c[0];
                grant_st = elig_c[1];
            end
        end
    end

    // Output process: zero-latency mux from the selected engine.
    always_comb begin
        sel_ld        = (state_q == S_LOAD_PKT)  || grant_ld;
        sel_st        = (state_q == S_STORE_PKT) || grant_st;
        noc_valid_out = (sel_ld && ld_valid_in) || (sel_st && st_valid_in);
        noc_data_out  = '0;
        if (sel_ld) begin
            noc_data_out = ld_data_in;
        end else if (sel_st) begin
            noc_data_out = st_data_in;
        end
        ld_ready_out  = sel_ld && noc_ready_in;
        st_ready_out  = sel_st && noc_ready_in;
        owner         = {sel_st, sel_ld};
    end

    assign flit_hs = noc_valid_out && noc_ready_in;
    assign hdr_hs  = (state_q == S_IDLE) && flit_hs;
    assign hdr_len = noc_data_out[MSG_LEN_LSB +: MSG_LEN_W];
    assign inc_c   = {hdr_hs && sel_st, hdr_hs && sel_ld};

    // Next-state process.
    always_comb begin
        state_d    = state_q;
        rr_st_d    = rr_st_q;
        flit_cnt_d = flit_cnt_q;
        len_d      = len_q;
        case (state_q)
            S_IDLE: begin
                if (hdr_hs) begin
                    rr_st_d    = sel_ld;
                    len_d      = hdr_len;
                    flit_cnt_d = '0;
                    // A header-only packet releases the output immediately.
                    if (hdr_len != '0) begin
                        state_d = sel_ld ? S_LOAD_PKT : S_STORE_PKT;
                    end
                end
            end
            S_LOAD_PKT, S_STORE_PKT: begin
                if (flit_hs) begin
                    if (flit_cnt_q == len_q - MSG_LEN_W'(1)) begin
                        state_d    = S_IDLE;
                        flit_cnt_d = '0;
                    end else begin
                        flit_cnt_d = flit_cnt_q + MSG_LEN_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_st_q    <= 1'b0;
            flit_cnt_q <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_st_q    <= rr_st_d;
            flit_cnt_q <= flit_cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
        end
    end

endmodule
